// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan multiplexer.
// SEG_SCAN_LZ_BLANK_EN adds the leading-zero blanking helper.
package seg_pkg;

   localparam int unsigned SEG_DIGITS = 4;
   localparam logic [SEG_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

   typedef logic [$clog2(SEG_DIGITS)-1:0] digit_idx_t;

`ifdef SEG_SCAN_LZ_BLANK_EN
   // Digit k >= 1 goes dark when it and every more significant nibble are zero.
   function automatic logic [SEG_DIGITS-1:0] lz_blank_mask(input logic [15:0] v);
      logic [SEG_DIGITS-1:0] m;
      m[0] = 1'b0;
      m[1] = (v[15:4] == 12'h000);
      m[2] = (v[15:8] == 8'h00);
      m[3] = (v[15:12] == 4'h0);
      return m;
   endfunction
`endif

endpackage

// File: rtl/seg_scan_tick.sv
// Slot prescaler: free-running 0..REFRESH_DIV-1 counter, tick on the terminal count.
module seg_scan_tick #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CntMax);
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered four-digit scan multiplexer with registered anode/dp/nibble outputs.
// Define SEG_SCAN_LZ_BLANK_EN to also dark leading-zero digits.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld,
   input  logic [15:0]           value,
   input  logic [SEG_DIGITS-1:0] dp_mask,
   input  logic [SEG_DIGITS-1:0] blank_mask,
   output logic [3:0]            digit_nib,
   output logic [SEG_DIGITS-1:0] an,
   output logic                  dp,
   output logic                  upd_pend,
   output logic                  frame_tick
);

   // Index parks on the last digit so the first tick after reset lights digit 0.
   localparam digit_idx_t IdxReset = digit_idx_t'(SEG_DIGITS - 1);

   logic tick;

   seg_scan_tick #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   digit_idx_t            idx_q, idx_d;
   logic [15:0]           act_val_q, act_val_d;
   logic [SEG_DIGITS-1:0] act_dp_q, act_dp_d;
   logic [SEG_DIGITS-1:0] act_blank_q, act_blank_d;
   logic [15:0]           pend_val_q, pend_val_d;
   logic [SEG_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic [SEG_DIGITS-1:0] pend_blank_q, pend_blank_d;
   logic                  upd_pend_q, upd_pend_d;
   logic [SEG_DIGITS-1:0] an_q, an_d;
   logic                  dp_q, dp_d;
   logic [3:0]            nib_q, nib_d;
   logic                  frame_tick_q, frame_tick_d;
   logic                  commit;
   logic [SEG_DIGITS-1:0] dark;

   always_comb begin
      idx_d        = idx_q;
      act_val_d    = act_val_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      upd_pend_d   = upd_pend_q;
      an_d         = an_q;
      dp_d         = dp_q;
      nib_d        = nib_q;
      dark         = '0;

      if (tick) begin
         idx_d = idx_q + digit_idx_t'(1);
      end
      commit = tick && (idx_d == '0);

      // A load landing on the commit tick bypasses the pending buffer.
      if (commit) begin
         upd_pend_d = 1'b0;
         if (ld) begin
            act_val_d   = value;
            act_dp_d    = dp_mask;
            act_blank_d = blank_mask;
         end else if (upd_pend_q) begin
            act_val_d   = pend_val_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
         end
      end else if (ld) begin
         pend_val_d   = value;
         pend_dp_d    = dp_mask;
         pend_blank_d = blank_mask;
         upd_pend_d   = 1'b1;
      end

      dark = act_blank_d;
`ifdef SEG_SCAN_LZ_BLANK_EN
      dark = dark | lz_blank_mask(act_val_d);
`endif

      if (tick) begin
         nib_d = act_val_d[{idx_d, 2'b00} +: 4];
         if (dark[idx_d]) begin
            an_d = AN_ALL_OFF;
            dp_d = 1'b1;
         end else begin
            an_d = ~(4'b0001 << idx_d);
            dp_d = ~act_dp_d[idx_d];
         end
      end

      frame_tick_d = commit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= IdxReset;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         upd_pend_q   <= 1'b0;
         an_q         <= AN_ALL_OFF;
         dp_q         <= 1'b1;
         nib_q        <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         upd_pend_q   <= upd_pend_d;
         an_q         <= an_d;
         dp_q         <= dp_d;
         nib_q        <= nib_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign dp         = dp_q;
   assign digit_nib  = nib_q;
   assign upd_pend   = upd_pend_q;
   assign frame_tick = frame_tick_q;

endmodule
